sig_round_pipe: RTL
===================

Name: sig_round_pipe

Overview:
- Pipelined, parametrised significand rounder for the FPU rounder path.
- Takes a left-aligned unrounded significand, the sign, a format select and a rounding mode.
- Produces the rounded significand with carry-out, an inexact flag and a pass-through tag.
- Generalises the combinational single/double rounder: configurable widths, a true sticky reduction over all discarded bits, a two-stage valid/ready pipeline and optional half precision.

Parameters:
- FW, 55: input significand width; legal range FW >= PD+2.
- PD, 53: double-precision significand bits, hidden bit included.
- PS, 24: single-precision significand bits.
- PH, 11: half-precision significand bits (used only with the macro).
- TAGW, 4: width of the sideband tag carried alongside each operand.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_s  in  1  sign of the operand.
- in_fmt  in  2  format: 00 single, 01 double, 10 half (macro), 11 reserved.
- in_rm  in  2  rounding mode: 00 RZ, 01 RNE, 10 RUP (+inf), 11 RDN (-inf).
- in_f  in  FW  unrounded significand, MSB-aligned at bit FW-1.
- in_tag  in  TAGW  sideband tag, returned unmodified.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sig  out  PD+1  bit PD is the carry-out; bits [PD-1:0] hold the rounded significand MSB-aligned, with unused low bits zero.
- out_inx  out  1  inexact (r|st).
- out_tag  out  TAGW  tag of this result.

Behaviour:
- Precision selection: P = PD, PS or PH from in_fmt.
  - Significand bits: in_f[FW-1:FW-P].
  - l = in_f[FW-P]; r = in_f[FW-P-1].
  - st = OR of in_f[FW-P-2:0], i.e. every lower bit, not a fixed position.
- Increment decision:
  - RZ: inc = 0.
  - RNE: inc = r&(l|st).
  - RUP: inc = ~s&(r|st).
  - RDN: inc = s&(r|st).
- Stage 1, registered on acceptance: truncated significand zero-extended to PD+1 bits, placed at [PD-1:PD-P]; inc; inx; tag.
- Stage 2, registered: sig + (inc << (PD-P)).
  - All-ones significand plus inc gives carry=1 and sig field all zero; the exponent adjust belongs to the consumer.
  - Bits below PD-P are always 0.
- Reserved format 11, or 10 without the macro: treated as double; out_inx is forced to 1 to flag misuse.
- Handshake:
  - A transfer happens on valid&ready at a rising edge.
  - Each stage holds a valid bit. A stage advances when the downstream stage is empty or is transferring in the same cycle.
  - in_ready = ~s1_v | (~s2_v | out_ready).
  - Latency is 2 cycles from input transfer to out_valid. Throughput is 1 per cycle with out_ready held high.
- Backpressure:
  - With out_ready low, out_* hold stable.
  - The pipeline fills to 2 entries, then in_ready drops combinationally in the same cycle.
  - No operand is dropped or duplicated.
- Simultaneous events: an input transfer and an output transfer in the same cycle on a full pipe must both occur, and ordering is preserved.
- Reset:
  - Asynchronous; clears s1_v and s2_v immediately, mid-transfer included.
  - All registered data, out_sig, out_inx and out_tag reset to 0; out_valid=0.
  - in_ready=1 once reset is deasserted.
  - Operands in flight are discarded.

Optional Feature:
- Macro: SIGRND_HALF_EN.
- Defined: in_fmt=10 selects P=PH with identical rounding and carry rules.
- Undefined: no PH datapath is built; 10 behaves as reserved (double precision, out_inx forced to 1).

Test Plan:
- Double, RNE, in_f = 53 ones followed by 2'b10 (FW=55, tie with l=1) -> after 2 cycles out_sig carry=1, sig=0, out_inx=1.
- Single, RNE, in_f[54:31]=24'h800001, bit30=1, rest 0 -> out_sig[52:29]=24'h800002, low 29 bits 0, carry=0, out_inx=1.
- Single, RNE, in_f[54:31]=24'h800000, bit30=1, bit0=1 only -> the full sticky reduction rounds up to 24'h800001. The same operand with RZ gives 24'h800000, out_inx=1.
- Double, RUP with in_s=1, and RDN with in_s=0, on in_f[1:0]=2'b01 -> no increment, out_inx=1. Exact in_f (low bits 0) in any mode -> out_inx=0.
- Backpressure:
  - Stimulus: stream tags 1..6 back-to-back; out_ready low on cycles 3-6; reset pulse on a later run.
  - Required response: in_ready falls with two entries held; results emerge in tag order 1..6 with none lost.
  - A reset pulse mid-stream clears out_valid asynchronously, and no stale result appears afterwards.
- SIGRND_HALF_EN defined:
  - Stimulus: half, RNE, in_f[54:44]=11'h7FF, bit43=1.
  - Required response: carry=1, sig=0.
  - Without the macro, the same stimulus rounds as double with out_inx=1.

Source files
------------

// File: rtl/sig_round_pipe.sv
// sig_round_pipe: two-stage valid/ready significand rounder (RZ/RNE/RUP/RDN) for single/double,
//   plus half precision when SIGRND_HALF_EN is defined. Latency 2 cycles, throughput 1/cycle.
// Backpressure: each stage stalls while its successor is full and not draining; in_ready is combinational.
module sig_round_pipe #(
  parameter int FW   = 55,
  parameter int PD   = 53,
  parameter int PS   = 24,
  parameter int PH   = 11,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_s,
  input  logic [1:0]      in_fmt,
  input  logic [1:0]      in_rm,
  input  logic [FW-1:0]   in_f,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PD:0]     out_sig,
  output logic            out_inx,
  output logic [TAGW-1:0] out_tag
);

  // Stage-1 state: truncated significand, the increment already weighted at the
  // result LSB position, the inexact flag and the tag.
  logic            s1_v;
  logic [PD:0]     s1_sig;
  logic [PD:0]     s1_add;
  logic            s1_inx;
  logic [TAGW-1:0] s1_tag;
  logic            s2_v;

  logic            s1_adv;
  logic            s2_adv;

  logic [PD:0]     sel_sig;
  logic [PD:0]     sel_step;
  logic            sel_l;
  logic            sel_r;
  logic            sel_st;
  logic            bad_fmt;
  logic            inc;
  logic [PD:0]     add;

  // A stage may load when it is empty or its content leaves this cycle.
  assign s2_adv    = ~s2_v | out_ready;
  assign s1_adv    = ~s1_v | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_v;

  // Precision selection and increment decision; anything not a supported format rounds as double.
  always_comb begin
    sel_sig  = '0;
    sel_step = '0;
    sel_l    = 1'b0;
    sel_r    = 1'b0;
    sel_st   = 1'b0;
    bad_fmt  = 1'b0;
    inc      = 1'b0;
    case (in_fmt)
      2'b00: begin
        sel_sig[PD-1 -: PS] = in_f[FW-1 -: PS];
        sel_step[PD-PS]     = 1'b1;
        sel_l               = in_f[FW-PS];
        sel_r               = in_f[FW-PS-1];
        sel_st              = |in_f[FW-PS-2:0];
      end
`ifdef SIGRND_HALF_EN
      2'b10: begin
        sel_sig[PD-1 -: PH] = in_f[FW-1 -: PH];
        sel_step[PD-PH]     = 1'b1;
        sel_l               = in_f[FW-PH];
        sel_r               = in_f[FW-PH-1];
        sel_st              = |in_f[FW-PH-2:0];
      end
`endif
      default: begin
        sel_sig[PD-1:0] = in_f[FW-1 -: PD];
        sel_step[0]     = 1'b1;
        sel_l           = in_f[FW-PD];
        sel_r           = in_f[FW-PD-1];
        sel_st          = |in_f[FW-PD-2:0];
        bad_fmt         = (in_fmt != 2'b01);
      end
    endcase
    case (in_rm)
      2'b00:   inc = 1'b0;
      2'b01:   inc = sel_r & (sel_l | sel_st);
      2'b10:   inc = ~in_s & (sel_r | sel_st);
      default: inc = in_s & (sel_r | sel_st);
    endcase
    add = inc ? sel_step : '0;
  end

  // Stage 1: capture the truncated operand on an input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_sig <= '0;
      s1_add <= '0;
      s1_inx <= 1'b0;
      s1_tag <= '0;
    end else if (s1_adv) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sig <= sel_sig;
        s1_add <= add;
        s1_inx <= sel_r | sel_st | bad_fmt;
        s1_tag <= in_tag;
      end
    end
  end

  // Stage 2: apply the increment; a carry out of the significand lands in bit PD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      out_sig <= '0;
      out_inx <= 1'b0;
      out_tag <= '0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_sig <= s1_sig + s1_add;
        out_inx <= s1_inx;
        out_tag <= s1_tag;
      end
    end
  end

endmodule
